// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_pkg
//  Description : Shared constants for the score display: segment patterns,
//                anode one-hot codes, digit count and small encode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_DIGIT0 = 4'b1110;
    localparam logic [3:0] AN_DIGIT1 = 4'b1101;
    localparam logic [3:0] AN_DIGIT2 = 4'b1011;
    localparam logic [3:0] AN_DIGIT3 = 4'b0111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [6:0] seg_encode(input bcd_digit_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = AN_DIGIT0;
            2'd1:    a = AN_DIGIT1;
            2'd2:    a = AN_DIGIT2;
            default: a = AN_DIGIT3;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter. One bit per cycle; the
//                shown BCD only changes when a conversion completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import flappy_pkg::*;
#(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [15:0]        bcd
);

    localparam int                 CNT_W        = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0]   c_last_shift = CNT_W'(SCORE_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_work_bcd;
    logic [SCORE_W-1:0] r_work_bin;
    logic [15:0]        r_shown;
    logic [14:0]        w_adj;

    // The thousands nibble never reaches 5 before a shift (result <= 9999),
    // so only the lower three nibbles need the add-3 correction.
    always_comb begin
        w_adj = r_work_bcd[14:0];
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (r_work_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_work_bcd <= '0;
            r_work_bin <= '0;
            r_shown    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work_bin <= bin;
                        r_work_bcd <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_work_bcd <= {w_adj, r_work_bin[SCORE_W-1]};
                    r_work_bin <= {r_work_bin[SCORE_W-2:0], 1'b0};
                    if (r_cnt == c_last_shift) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_shown <= r_work_bcd;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = (r_state == S_DONE);
    // Forward the finished result during DONE so the display register picks it
    // up on the same edge that commits it.
    assign bcd  = done ? r_work_bcd : r_shown;

endmodule
`default_nettype wire

// File: rtl/score_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : score_seg_display
//  Description : Binary score to multiplexed 4-digit active-low 7-segment
//                drive. Optional macro: LEADING_ZERO_BLANK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_seg_display
    import flappy_pkg::*;
#(
    parameter int SCORE_W  = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               busy
);

    localparam int               PRE_W     = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0]   r_pre;
    logic               w_tick;
    logic [1:0]         r_idx;
    logic [SCORE_W-1:0] r_last_score;
    logic [SCORE_W-1:0] r_pend_score;
    logic               w_start;
    logic               w_conv_busy;
    logic               w_conv_done;
    logic [15:0]        w_bcd;
    bcd_digit_t         w_digit;
    logic               w_blank;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    assign w_tick = (r_pre == c_pre_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Changes arriving while busy are ignored; the compare re-fires in IDLE.
    assign w_start = !w_conv_busy && (score != r_last_score);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_score <= '0;
            r_pend_score <= '0;
        end else begin
            if (w_start) begin
                r_pend_score <= score;
            end
            if (w_conv_done) begin
                r_last_score <= r_pend_score;
            end
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (score),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    assign w_digit = w_bcd[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = (w_bcd[15:4]  == 12'd0);
            2'd2:    w_blank = (w_bcd[15:8]  == 8'd0);
            2'd3:    w_blank = (w_bcd[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_blank ? AN_OFF    : an_select(r_idx);
            r_seg <= w_blank ? SEG_BLANK : seg_encode(w_digit);
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;
    assign busy = w_conv_busy;

endmodule
`default_nettype wire

// File: tb/tb_score_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_seg_display
//  Description : Directed scoreboard bench for score_seg_display (SCAN_DIV=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_seg_display;

    localparam int SCORE_W  = 8;
    localparam int SCAN_DIV = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [SCORE_W-1:0] score;
    logic [3:0]         an;
    logic [6:0]         seg;
    logic               dp;
    logic               busy;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   disp   = 0;

    score_seg_display #(
        .SCORE_W  (SCORE_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic push_exp(input string tag, input logic [3:0] a, input logic [6:0] s, input logic b);
        exp_t e;
        e.tag  = tag;
        e.an   = a;
        e.seg  = s;
        e.busy = b;
        sb.push_back(e);
    endtask

    // Expected outputs for the current cycle from the scan timing and shown value.
    task automatic push_model(input string tag, input logic b);
        int         slot;
        int         p;
        logic [3:0] a;
        logic [6:0] s;
        slot = ((cyc - 1) / SCAN_DIV) % 4;
        p    = 1;
        for (int k = 0; k < slot; k++) p = p * 10;
        a = 4'b1111;
        a[slot] = 1'b0;
        s = ref_seg((disp / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && disp < p) begin
            a = 4'b1111;
            s = 7'h7F;
        end
`endif
        push_exp(tag, a, s, b);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        checks += 3;
        assert (an === e.an) else begin
            errors++;
            $display("FAIL %s cyc=%0d an got %b want %b", e.tag, cyc, an, e.an);
            $error("%s an", e.tag);
        end
        assert (seg === e.seg) else begin
            errors++;
            $display("FAIL %s cyc=%0d seg got %b want %b", e.tag, cyc, seg, e.seg);
            $error("%s seg", e.tag);
        end
        assert (busy === e.busy) else begin
            errors++;
            $display("FAIL %s cyc=%0d busy got %b want %b", e.tag, cyc, busy, e.busy);
            $error("%s busy", e.tag);
        end
    endtask

    task automatic step(input string tag, input logic b);
        @(posedge clk);
        cyc++;
        push_model(tag, b);
        #1;
        pop_check();
    endtask

    task automatic reset_check(input string tag);
        @(posedge clk);
        push_exp(tag, 4'b1111, 7'h7F, 1'b0);
        #1;
        pop_check();
    endtask

    initial begin
        rst   = 1'b1;
        score = '0;
        repeat (2) @(posedge clk);
        reset_check("reset");
        checks++;
        assert (dp === 1'b1) else begin
            errors++;
            $display("FAIL dp got %b want 1", dp);
            $error("dp");
        end
        rst  = 1'b0;
        cyc  = 0;
        disp = 0;
        repeat (17) step("scan0", 1'b0);

        score = 8'd17;
        repeat (9) step("conv17_busy", 1'b1);
        disp = 17;
        repeat (16) step("show17", 1'b0);

        score = 8'd255;
        repeat (9) step("conv255_busy", 1'b1);
        disp = 255;
        repeat (16) step("show255", 1'b0);

        score = 8'd5;
        repeat (2) step("conv5_busy", 1'b1);
        score = 8'd20;
        repeat (7) step("conv5_busy_late", 1'b1);
        disp = 5;
        step("show5", 1'b0);
        repeat (9) step("conv20_busy", 1'b1);
        disp = 20;
        repeat (16) step("show20", 1'b0);

        score = 8'd7;
        repeat (9) step("conv7_busy", 1'b1);
        disp = 7;
        repeat (16) step("show7", 1'b0);

        score = 8'd99;
        repeat (3) step("conv99_busy", 1'b1);
        rst = 1'b1;
        reset_check("mid_reset");
        rst  = 1'b0;
        cyc  = 0;
        disp = 0;
        repeat (9) step("restart99_busy", 1'b1);
        disp = 99;
        repeat (16) step("show99", 1'b0);

        score = 8'd0;
        repeat (9) step("conv0_busy", 1'b1);
        disp = 0;
        repeat (16) step("show0", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
